sword_board_disp: RTL and testbench
===================================

# sword_board_disp

Serial front-panel driver for the Sword board: renders a 32-bit value as eight hex digits on the 7-segment display and a 16-bit pattern on the discrete LEDs. Both displays sit behind shift-register chains. The block periodically snapshots its inputs and serialises them over two clock/data/latch interfaces. It sits at SoC top level, clocked by the system clock, and is fed by whichever debug/status source the top selects.

## Interface
- `DIV`, 2: half-period of the serial clock in `clk` cycles (≥1).
- `REFRESH`, 4096: `clk` cycles between frame starts; must exceed the frame length (2 + 128·DIV).

- `clk` in 1: system clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `en` in 8: per-digit enable; bit i drives digit i (digit 7 is leftmost).
- `data` in 32: hex value; `data[4i+3:4i]` is digit i.
- `dot` in 8: per-digit decimal point; 1 lights the point.
- `led` in 16: LED pattern; 1 lights the LED. Narrower sources are zero-extended at the instance.
- `seg_clk` out 1: segment chain shift clock.
- `seg_do` out 1: segment chain serial data.
- `seg_en` out 1: segment output enable/latch; low while shifting.
- `seg_clr_n` out 1: segment chain clear, active low.
- `led_clk`, `led_do`, `led_en`, `led_clr_n` out 1 each: same roles for the LED chain.

## Operation
- States: IDLE → LOAD → SHIFT → LATCH → IDLE.
- The refresh counter counts down from REFRESH−1 and wraps. A frame starts (LOAD) when the counter is 0 and the FSM is in IDLE.
- LOAD:
  - Capture `en`, `data`, `dot` and `led` into shadow registers. Input changes mid-frame do not affect the frame in flight.
  - Build a 64-bit segment word: digit 7 byte first, digit 0 last.
  - Build a 16-bit LED word: `~led`, with bit 15 first.
  - Drive `seg_en` and `led_en` low.
- Segment byte layout is {dp,g,f,e,d,c,b,a}, active-low.
- Hex encoding with dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- `dot[i]=1` clears bit 7 of digit i's byte.
- `en[i]=0` forces digit i's byte to FF, ignoring the dot.
- SHIFT: each bit slot lasts 2·DIV cycles.
  - `*_do` = current MSB and `*_clk` = 0 for DIV cycles, then `*_clk` = 1 for DIV cycles.
  - At the end of the slot the word shifts left one bit.
  - Both chains share the same slot timing, starting together.
  - The LED chain stops after 16 slots: `led_clk` held 0, `led_do` held 0. The segment chain runs 64 slots.
- LATCH: one cycle after the last segment slot. Both `*_clk` are 0; then `seg_en` and `led_en` return high.
- `*_clr_n` is low during reset and goes high on the first `clk` edge after `rstn` rises, then stays high.

## Timing
- Reset values (asynchronous):
  - `seg_clk`, `led_clk`, `seg_do`, `led_do`: 0.
  - `seg_en`, `led_en`: 1.
  - `seg_clr_n`, `led_clr_n`: 0.
  - FSM in IDLE; refresh counter 0.
- First LOAD occurs on the first `clk` edge after `rstn` deasserts.
- Frame length is 1 (LOAD) + 128·DIV (SHIFT) + 1 (LATCH) cycles; 258 for DIV=2. Frames start every REFRESH cycles.
- Data setup to the clock rising edge is DIV cycles. Data is stable from the change until the end of the slot.
- Asserting `rstn` low mid-frame aborts the frame immediately and returns all outputs to their reset values.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset, then release with DIV=2 → `*_clr_n` rises on the first edge. LOAD on the same edge; `seg_en`/`led_en` fall. `seg_en` rises again 258 cycles after LOAD.
- `data`=32'h01234567, `en`=FF, `dot`=00 → 64 bits sampled on the `seg_clk` rising edges equal C0 F9 A4 B0 99 92 82 F8, MSB first.
- `data`=32'hFEDCBA98, `dot`=8'h81, `en`=8'hFE → bytes 0E 86 A1 C6 83 88 90 FF. Digit 7 has the dp bit cleared. Digit 0 is blank despite its dot.
- `led`=16'h0005 → 16 bits sampled on the `led_clk` rising edges equal FFFA. After slot 16, `led_clk` stays 0 while `seg_clk` keeps toggling.
- Change `data` during SHIFT → the current frame is unchanged; the next frame (REFRESH cycles after the previous LOAD) carries the new value.
- Assert `rstn` at slot 30 → outputs return to reset values at once. The frame restarts from the first bit after release.

Source files
------------

// File: rtl/sword_board_disp.sv
// sword_board_disp: serialises eight hex digits and a 16-bit LED pattern onto two shift-register chains
module sword_board_disp #(
    parameter int DIV     = 2,
    parameter int REFRESH = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  en,
    input  logic [31:0] data,
    input  logic [7:0]  dot,
    input  logic [15:0] led,
    output logic        seg_clk,
    output logic        seg_do,
    output logic        seg_en,
    output logic        seg_clr_n,
    output logic        led_clk,
    output logic        led_do,
    output logic        led_en,
    output logic        led_clr_n
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
    localparam int PW = $clog2(2 * DIV);
    localparam int CW = $clog2(REFRESH);
    // active-low {dp,g,f,e,d,c,b,a} patterns, digit 0 in the lowest byte
    localparam logic [127:0] HEX = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ph, ph_n;
    logic [5:0]    slot, slot_n;
    logic [63:0]   seg_word, seg_word_n, seg_load;
    logic [15:0]   led_word, led_word_n;
    logic          start, slot_end, shifting, hi, led_act;
    logic          seg_clk_d, seg_do_d, led_clk_d, led_do_d, en_d;
    assign start    = (state == IDLE) && (cnt == '0);
    assign slot_end = (state == SHIFT) && (ph == PW'(2 * DIV - 1));
    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end
    // next-state: one LOAD cycle, 64 slots of SHIFT, one LATCH cycle
    always_comb begin
        state_n = start ? LOAD :
                  state == LOAD ? SHIFT :
                  (slot_end && slot == 6'd63) ? LATCH :
                  state == LATCH ? IDLE : state;
    end
    // frame word from the live inputs, digit 7 in the top byte; disabled digits go fully dark
    always_comb begin
        seg_load = '0;
        for (int i = 0; i < 8; i++)
            seg_load[8*i +: 8] = en[i] ? (HEX[{data[4*i +: 4], 3'b000} +: 8] & {~dot[i], 7'h7F}) : 8'hFF;
    end
    // next values of the slot timing and the shadow words
    always_comb begin
        ph_n       = (state == SHIFT && !slot_end) ? ph + 1'b1 : '0;
        slot_n     = (state == LOAD) ? 6'd0 : slot_end ? slot + 6'd1 : slot;
        seg_word_n = start ? seg_load : slot_end ? {seg_word[62:0], 1'b0} : seg_word;
        led_word_n = start ? ~led : slot_end ? {led_word[14:0], 1'b0} : led_word;
    end
    // output decode from the upcoming state so every pin comes straight off a flop
    always_comb begin
        shifting  = state_n == SHIFT;
        hi        = ph_n >= PW'(DIV);
        led_act   = slot_n[5:4] == 2'b00;
        seg_clk_d = shifting && hi;
        seg_do_d  = shifting && seg_word_n[63];
        led_clk_d = shifting && led_act && hi;
        led_do_d  = shifting && led_act && led_word_n[15];
        en_d      = state_n == IDLE;
    end
    // refresh counter, shift datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            ph        <= '0;
            slot      <= '0;
            seg_word  <= '0;
            led_word  <= '0;
            seg_clk   <= 1'b0;
            seg_do    <= 1'b0;
            seg_en    <= 1'b1;
            seg_clr_n <= 1'b0;
            led_clk   <= 1'b0;
            led_do    <= 1'b0;
            led_en    <= 1'b1;
            led_clr_n <= 1'b0;
        end else begin
            cnt       <= (cnt == '0) ? CW'(REFRESH - 1) : cnt - 1'b1;
            ph        <= ph_n;
            slot      <= slot_n;
            seg_word  <= seg_word_n;
            led_word  <= led_word_n;
            seg_clk   <= seg_clk_d;
            seg_do    <= seg_do_d;
            seg_en    <= en_d;
            seg_clr_n <= 1'b1;
            led_clk   <= led_clk_d;
            led_do    <= led_do_d;
            led_en    <= en_d;
            led_clr_n <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sword_board_disp.sv
// tb_sword_board_disp: cycle-accurate frame model plus literal frame checks for sword_board_disp
module tb_sword_board_disp;
    localparam int DIV = 2, REFRESH = 4096, FL = 2 + 128 * DIV;
    logic clk = 0, rstn = 0;
    logic [7:0] en, dot;
    logic [31:0] data;
    logic [15:0] led;
    logic seg_clk, seg_do, seg_en, seg_clr_n, led_clk, led_do, led_en, led_clr_n;
    int total = 0, bad = 0;
    logic [7:0] hexv [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    sword_board_disp #(.DIV(DIV), .REFRESH(REFRESH)) dut (
        .clk(clk), .rstn(rstn), .en(en), .data(data), .dot(dot), .led(led),
        .seg_clk(seg_clk), .seg_do(seg_do), .seg_en(seg_en), .seg_clr_n(seg_clr_n),
        .led_clk(led_clk), .led_do(led_do), .led_en(led_en), .led_clr_n(led_clr_n)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] seg_frame(input logic [7:0] e, input logic [31:0] d, input logic [7:0] p);
        logic [63:0] w;
        logic [7:0] b;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            b = hexv[d[4*i +: 4]];
            if (p[i]) b[7] = 1'b0;
            if (!e[i]) b = 8'hFF;
            w = {w[55:0], b};
        end
        return w;
    endfunction

    // model: n = clk edges since reset release; frames open on every REFRESH-th edge starting with the first
    int n = 0;
    logic [63:0] m_seg = '0;
    logic [15:0] m_led = '0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) n = 0;
        else begin
            if (n % REFRESH == 0) begin
                m_seg = seg_frame(en, data, dot);
                m_led = ~led;
            end
            n++;
        end
    end

    // per-cycle compare against the model, sampled mid-period
    int k, s, p;
    logic c, lc;
    always @(negedge clk) begin
        if (n == 0) chk("reset_outs", {seg_clk, seg_do, seg_en, seg_clr_n, led_clk, led_do, led_en, led_clr_n}, 8'b0010_0010);
        else begin
            k = (n - 1) % REFRESH;
            c = 0;
            lc = 0;
            if (k >= 1 && k <= 128 * DIV) begin
                s = (k - 1) / (2 * DIV);
                p = (k - 1) % (2 * DIV);
                c = p >= DIV;
                lc = c && s < 16;
                chk("seg_do", seg_do, m_seg[63-s]);
                chk("led_do", led_do, s < 16 ? m_led[15-s] : 1'b0);
            end
            chk("ctl", {seg_clk, led_clk, seg_en, led_en, seg_clr_n, led_clr_n}, {c, lc, k >= FL, k >= FL, 2'b11});
        end
    end

    // bits as a chain would see them on the shift-clock rising edges
    logic [63:0] cap_seg = '0;
    logic [15:0] cap_led = '0;
    int nseg = 0, nled = 0;
    logic pen = 1, psc = 0, plc = 0;
    always @(negedge clk) begin
        if (pen && !seg_en) begin
            cap_seg = '0;
            cap_led = '0;
            nseg = 0;
            nled = 0;
        end
        if (!psc && seg_clk) begin
            cap_seg = {cap_seg[62:0], seg_do};
            nseg++;
        end
        if (!plc && led_clk) begin
            cap_led = {cap_led[14:0], led_do};
            nled++;
        end
        pen = seg_en;
        psc = seg_clk;
        plc = led_clk;
    end

    task automatic frame(input string nm, input bit lit, input logic [63:0] es, input logic [15:0] el,
                         input bit mid, input logic [7:0] ne, input logic [31:0] nd, input logic [7:0] np,
                         input logic [15:0] nl);
        int t, lows;
        t = 0;
        while (seg_en && t < REFRESH + 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_start"}, seg_en, 1'b0);
        lows = 0;
        while (!seg_en && lows < 400) begin
            lows++;
            @(negedge clk);
            if (mid && lows == 50) begin
                en = ne;
                data = nd;
                dot = np;
                led = nl;
            end
        end
        #1;
        chk({nm, "_len"}, lows, FL);
        chk({nm, "_nbits"}, {nseg, nled}, {32'd64, 32'd16});
        if (lit) begin
            chk({nm, "_seg"}, cap_seg, es);
            chk({nm, "_led"}, cap_led, el);
        end
    endtask

    logic [7:0] r_en, r_dot;
    logic [31:0] r_data;
    logic [15:0] r_led;
    initial begin
        en = 8'hFF;
        data = 32'h01234567;
        dot = 8'h00;
        led = 16'h0005;
        repeat (3) @(negedge clk);
        rstn = 1;
        frame("f1", 1, 64'hC0F9A4B0999282F8, 16'hFFFA, 1, 8'hFE, 32'hFEDCBA98, 8'h81, 16'h8001);
        frame("f2", 1, 64'h0E86A1C6838890FF, 16'h7FFE, 1, 8'hFF, 32'h00000000, 8'h00, 16'h0000);
        r_en = 8'($urandom); r_data = $urandom; r_dot = 8'($urandom); r_led = 16'($urandom);
        frame("f3", 1, 64'hC0C0C0C0C0C0C0C0, 16'hFFFF, 1, r_en, r_data, r_dot, r_led);
        for (int i = 0; i < 4; i++) begin
            r_en = 8'($urandom); r_data = $urandom; r_dot = 8'($urandom); r_led = 16'($urandom);
            frame("fr", 0, '0, '0, 1, r_en, r_data, r_dot, r_led);
        end
        en = 8'hFF;
        data = 32'h01234567;
        dot = 8'h00;
        led = 16'h0005;
        for (int t = 0; seg_en && t < REFRESH + 20; t++) @(negedge clk);
        repeat (1 + 30 * 2 * DIV) @(negedge clk);
        @(posedge clk);
        #2 rstn = 0;
        #1 chk("abort", {seg_clk, seg_do, seg_en, seg_clr_n, led_clk, led_do, led_en, led_clr_n}, 8'b0010_0010);
        repeat (3) @(negedge clk);
        rstn = 1;
        frame("rst", 1, 64'hC0F9A4B0999282F8, 16'hFFFA, 0, '0, '0, '0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
